// File: rtl/divider_control.sv
// divider_control: restoring shift-subtract divider, 2N-bit dividend / N-bit divisor -> quotient, remainder, v (overflow/div-by-zero), with st/idle/done handshake
module divider_control #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           st,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           v,
  output logic           idle,
  output logic           done
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CHK, SHSUB, DONE} state_t;
  state_t state, state_n;
  logic [2*N-1:0] acc, acc_n;
  logic [N-1:0] dsr, dsr_n;
  logic [CW-1:0] cnt, cnt_n;
  logic v_n, ovf, ge;
  logic [N:0] t, diff;
  assign t = acc[2*N-1:N-1];
  assign ge = t >= {1'b0, dsr};
  assign diff = t - {1'b0, dsr};
  assign ovf = (dsr == '0) || (acc[2*N-1:N] >= dsr);
  assign quotient = acc[N-1:0];
  assign remainder = acc[2*N-1:N];
  assign idle = state == IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      dsr <= '0;
      cnt <= '0;
      v <= 1'b0;
    end else begin
      state <= state_n;
      acc <= acc_n;
      dsr <= dsr_n;
      cnt <= cnt_n;
      v <= v_n;
    end
  end
  always_comb begin
    state_n = state;
    acc_n = acc;
    dsr_n = dsr;
    cnt_n = cnt;
    v_n = v;
    case (state)
      IDLE: if (st) begin
        state_n = CHK;
        acc_n = dividend;
        dsr_n = divisor;
        cnt_n = '0;
        v_n = 1'b0;
      end
      CHK: begin
        state_n = ovf ? DONE : SHSUB;
        v_n = ovf;
      end
      SHSUB: begin
        acc_n = ge ? {diff[N-1:0], acc[N-2:0], 1'b1} : {acc[2*N-2:0], 1'b0};
        cnt_n = cnt + CW'(1);
        state_n = (cnt == CW'(N - 1)) ? DONE : SHSUB;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_divider_control.sv
// tb_divider_control: directed self-checking bench for divider_control with N=4
module tb_divider_control;
  logic clk = 1'b0;
  logic rst, st;
  logic [7:0] dividend;
  logic [3:0] divisor, quotient, remainder;
  logic v, idle, done;
  int errors = 0;
  int checks = 0;
  divider_control #(.N(4)) dut (
    .clk(clk), .rst(rst), .st(st), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .v(v), .idle(idle), .done(done)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic [7:0] a, input logic [3:0] b,
                     input int lat, input logic [3:0] q, input logic [3:0] r, input logic ov);
    int c;
    dividend = a;
    divisor = b;
    st = 1'b1;
    tick();
    st = 1'b0;
    dividend = 8'hff;
    divisor = 4'h1;
    c = 1;
    while (!done && c < 20) begin
      tick();
      c++;
    end
    chk({tag, "_latency"}, c, lat);
    chk({tag, "_quotient"}, quotient, q);
    chk({tag, "_remainder"}, remainder, r);
    chk({tag, "_v"}, v, ov);
    chk({tag, "_idle_at_done"}, idle, 0);
    tick();
    chk({tag, "_done_one_cycle"}, done, 0);
    chk({tag, "_idle_after"}, idle, 1);
    chk({tag, "_v_hold"}, v, ov);
    chk({tag, "_quotient_hold"}, quotient, q);
  endtask
  initial begin
    int c, ndone, d1, d2, idles;
    logic [3:0] qs, rs;
    rst = 1'b1;
    st = 1'b0;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_idle", idle, 1);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_v", v, 0);
    tick();
    run("normal", 8'd135, 4'd13, 6, 4'd10, 4'd5, 1'b0);
    run("maxq", 8'd239, 4'd15, 6, 4'd15, 4'd14, 1'b0);
    run("overflow", 8'd200, 4'd5, 2, 4'd8, 4'd12, 1'b1);
    run("divzero", 8'd7, 4'd0, 2, 4'd7, 4'd0, 1'b1);
    run("v_cleared", 8'd135, 4'd13, 6, 4'd10, 4'd5, 1'b0);
    dividend = 8'd135;
    divisor = 4'd13;
    st = 1'b1;
    tick();
    ndone = 0;
    qs = '0;
    rs = '0;
    for (int k = 1; k <= 12; k++) begin
      if (done) begin
        ndone++;
        qs = quotient;
        rs = remainder;
        chk("toggle_done_cycle", k, 6);
      end
      st = (k <= 6) ? k[0] : 1'b0;
      dividend = 8'($urandom);
      divisor = 4'($urandom);
      tick();
    end
    chk("toggle_done_count", ndone, 1);
    chk("toggle_quotient", qs, 10);
    chk("toggle_remainder", rs, 5);
    chk("toggle_idle_hold", idle, 1);
    chk("toggle_quotient_hold", quotient, 10);
    dividend = 8'd239;
    divisor = 4'd15;
    st = 1'b1;
    tick();
    d1 = 0;
    d2 = 0;
    idles = 0;
    for (int k = 1; k <= 14; k++) begin
      if (done && d1 == 0) d1 = k;
      else if (done && d2 == 0) d2 = k;
      if (idle && d1 != 0 && d2 == 0) idles++;
      if (k == 14) st = 1'b0;
      tick();
    end
    chk("b2b_first_done", d1, 6);
    chk("b2b_second_done", d2, 13);
    chk("b2b_idle_gap", idles, 1);
    chk("b2b_idle_end", idle, 1);
    chk("b2b_quotient", quotient, 15);
    dividend = 8'd135;
    divisor = 4'd13;
    st = 1'b1;
    tick();
    st = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_idle", idle, 1);
    chk("midrst_done", done, 0);
    chk("midrst_quotient", quotient, 0);
    chk("midrst_remainder", remainder, 0);
    chk("midrst_v", v, 0);
    c = 0;
    for (int k = 0; k < 8; k++) begin
      if (done) c++;
      tick();
    end
    chk("midrst_no_done", c, 0);
    run("after_rst", 8'd135, 4'd13, 6, 4'd10, 4'd5, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  always @(negedge clk) begin
    if (!rst) chk("idle_done_exclusive", idle & done, 0);
  end
endmodule
